sign_compressor: RTL and testbench

//  Inverse of the immediate sign-extension path: narrows a REG_DATA_WIDTH two's-complement word to a DATA_2_WIDTH field.

---
 rtl/sign_compressor_pkg.sv | 7 +
 rtl/sign_compressor_sat_narrow.sv | 11 +
 rtl/sign_compressor.sv | 69 ++++++
 tb/tb_sign_compressor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sign_compressor_pkg.sv
// sign_compressor_pkg: shared FSM state encodings and default widths for narrowing units
package sign_compressor_pkg;
  localparam int REG_DATA_WIDTH_D = 16;
  localparam int DATA_2_WIDTH_D = 4;
  localparam int CNT_WIDTH_D = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sign_compressor_sat_narrow.sv
// sat_narrow: orig[W], fits -> data_out[N], low bits of orig when it fits, otherwise the signed N-bit endpoint
module sat_narrow #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic [W-1:0] orig,
  input  logic         fits,
  output logic [N-1:0] data_out
);
  always_comb data_out = fits ? orig[N-1:0] : {orig[W-1], {(N-1){~orig[W-1]}}};
endmodule

// File: rtl/sign_compressor.sv
// sign_compressor: narrows a two's-complement word to a saturated DATA_2_WIDTH field (valid/ready in, valid/ready out; min_width, fits, sat)
module sign_compressor
  import sign_compressor_pkg::*;
#(
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_D,
  parameter int DATA_2_WIDTH = DATA_2_WIDTH_D,
  parameter int CNT_WIDTH = CNT_WIDTH_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_DATA_WIDTH-1:0] data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_2_WIDTH-1:0]   data_out,
  output logic [CNT_WIDTH-1:0]      min_width,
  output logic                      fits,
  output logic                      sat
);
  localparam int M = REG_DATA_WIDTH - 1;
  state_t state;
  logic [REG_DATA_WIDTH-1:0] orig, shreg;
  logic [CNT_WIDTH-1:0] cnt;
  logic fits_n, redundant;
  logic [DATA_2_WIDTH-1:0] narrowed;
  assign in_ready = rst & (state == IDLE);
  assign out_valid = state == DONE;
  assign fits_n = cnt <= CNT_WIDTH'(DATA_2_WIDTH);
  assign redundant = (cnt > CNT_WIDTH'(1)) & (shreg[M] == shreg[M-1]);
  sat_narrow #(.W(REG_DATA_WIDTH), .N(DATA_2_WIDTH)) u_sat (
    .orig(orig),
    .fits(fits_n),
    .data_out(narrowed)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      orig <= '0;
      shreg <= '0;
      cnt <= '0;
      data_out <= '0;
      min_width <= '0;
      fits <= 1'b0;
      sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          orig <= data_in;
          shreg <= data_in;
          cnt <= CNT_WIDTH'(REG_DATA_WIDTH);
          state <= SCAN;
        end
        SCAN: if (redundant) begin
          shreg <= shreg << 1;
          cnt <= cnt - 1'b1;
        end else begin
          min_width <= cnt;
          fits <= fits_n;
          sat <= ~fits_n;
          data_out <= narrowed;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sign_compressor.sv
// tb_sign_compressor: directed and random checks of sign_compressor against an arithmetic range model
module tb_sign_compressor;
  localparam int W = 16;
  localparam int N = 4;
  localparam int C = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] data_in = '0;
  logic in_ready, out_valid, fits, sat;
  logic [N-1:0] data_out;
  logic [C-1:0] min_width;
  int vectors = 0;
  int miscompares = 0;
  sign_compressor #(.REG_DATA_WIDTH(W), .DATA_2_WIDTH(N), .CNT_WIDTH(C)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .min_width(min_width),
    .fits(fits),
    .sat(sat)
  );
  always #5 clk = ~clk;
  function automatic int ref_mw(input int v);
    for (int w = 1; w <= W; w++)
      if (v >= -(1 << (w - 1)) && v <= (1 << (w - 1)) - 1) return w;
    return W;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic accept(input logic [W-1:0] x);
    data_in = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in = W'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask
  task automatic check_fields(input logic [W-1:0] x);
    int v, mw, cl;
    v = int'($signed(x));
    mw = ref_mw(v);
    cl = v < -(1 << (N - 1)) ? -(1 << (N - 1)) : v > (1 << (N - 1)) - 1 ? (1 << (N - 1)) - 1 : v;
    chk("out_valid", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("min_width", min_width, mw);
    chk("fits", fits, mw <= N);
    chk("sat", sat, mw > N);
    chk("data_out", data_out, cl[N-1:0]);
    if (mw <= N) chk("roundtrip", {{(W-N){data_out[N-1]}}, data_out}, x);
  endtask
  task automatic run(input logic [W-1:0] x);
    int lat;
    accept(x);
    wait_done(lat);
    chk("latency", lat, W - ref_mw(int'($signed(x))) + 1);
    check_fields(x);
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask
  initial begin
    logic [W-1:0] x;
    logic signed [W-1:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_min_width", min_width, 0);
    chk("rst_fits", fits, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);
    run(16'h0005); release_out();
    run(16'hFFF8); release_out();
    run(16'h0008); release_out();
    run(16'h8000); release_out();
    run(16'h0000); release_out();
    run(16'hFFFF); release_out();
    run(16'h7FFF); release_out();
    run(16'hFFF7); release_out();
    run(16'h0008);
    repeat (5) begin
      data_in = W'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_fields(16'h0008);
    end
    in_valid = 1'b0;
    release_out();
    accept(16'h0001);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_min_width", min_width, 0);
    chk("mid_rst_sat", sat, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_result", out_valid, 0);
    end
    for (int i = 0; i < 1000; i++) begin
      r = W'($urandom);
      x = r >>> $urandom_range(0, W - 1);
      run(x);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        chk("stall_valid", out_valid, 1);
      end
      release_out();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
